// File: rtl/lzc_pkg.sv
// Shared types and elaboration helpers for the pipelined leading/trailing-zero counter.
package lzc_pkg;

  localparam int unsigned LZC_ZW_MAX = 6;

  typedef enum logic {
    LZC_MODE_LEAD  = 1'b0,
    LZC_MODE_TRAIL = 1'b1
  } lzc_mode_e;

  typedef struct packed {
    logic                  v;
    logic [LZC_ZW_MAX-1:0] z;
  } lzc_node_t;

  function automatic int unsigned lzc_cw(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

  // Merge level after which pipeline stage 'stage' places its register.
  function automatic int unsigned lzc_stage_level(input int unsigned stage,
                                                  input int unsigned levels,
                                                  input int unsigned stages);
    return (stage * levels + stages - 1) / stages;
  endfunction

  // True when an intermediate (non-output) stage register sits after 'level'.
  function automatic bit lzc_is_cut(input int unsigned level,
                                    input int unsigned levels,
                                    input int unsigned stages);
    for (int unsigned i = 1; i < stages; i++) begin
      if (lzc_stage_level(i, levels, stages) == level) return 1'b1;
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/lzc_merge.sv
// Combines two (valid, zero-count) halves of an LZC tree into their parent node.
module lzc_merge
  import lzc_pkg::*;
#(
  parameter int unsigned ZW = 1
) (
  input  logic          i_vl,
  input  logic [ZW-1:0] i_zl,
  input  logic          i_vr,
  input  logic [ZW-1:0] i_zr,
  output logic          o_v_c,
  output logic [ZW:0]   o_z_c
);

  assign o_v_c = i_vl & i_vr;
  assign o_z_c = {i_vl, i_vl ? i_zr : i_zl};

endmodule

// File: rtl/lzc_pipe_module.sv
// Pipelined leading/trailing-zero counter with valid/ready handshake.
// Define LZC_SKID_EN for a 2-entry output skid buffer and a registered oready.
module lzc_pipe_module
  import lzc_pkg::*;
#(
  parameter  int unsigned WIDTH  = 32,
  parameter  int unsigned STAGES = 2,
  localparam int unsigned CW     = lzc_cw(WIDTH)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             ivalid,
  output logic             oready,
  input  logic [WIDTH-1:0] datain_a,
  input  logic             mode,
  output logic             ovalid,
  input  logic             iready,
  output logic [CW-1:0]    count,
  output logic             zero
);

  localparam int unsigned L = $clog2(WIDTH);

  logic              w_en;
  logic [WIDTH-1:0]  w_op;
  logic [STAGES-1:0] r_vld;
  logic [CW-1:0]     r_count;
  logic              r_zero;
  logic [CW-1:0]     w_count;
  lzc_node_t         w_root;

  // Trailing-zero mode reuses the leading-zero tree on the mirrored operand.
  always_comb begin
    w_op = datain_a;
    if (lzc_mode_e'(mode) == LZC_MODE_TRAIL) begin
      for (int unsigned i = 0; i < WIDTH; i++) w_op[i] = datain_a[WIDTH-1-i];
    end
  end

  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int unsigned NK = WIDTH >> k;
    logic [NK-1:0]        w_v;
    logic [NK-1:0]        w_pv;
    logic [NK-1:0][k-1:0] w_z;
    logic [NK-1:0][k-1:0] w_pz;

    if (k == 1) begin : g_leaf
      for (genvar j = 0; j < NK; j++) begin : g_node
        assign w_v[j] = ~|w_op[2*j +: 2];
        assign w_z[j] = ~w_op[2*j+1] & w_op[2*j];
      end
    end else begin : g_merge
      for (genvar j = 0; j < NK; j++) begin : g_node
        lzc_merge #(.ZW(k-1)) u_merge (
          .i_vl  (g_lvl[k-1].w_pv[2*j+1]),
          .i_zl  (g_lvl[k-1].w_pz[2*j+1]),
          .i_vr  (g_lvl[k-1].w_pv[2*j]),
          .i_zr  (g_lvl[k-1].w_pz[2*j]),
          .o_v_c (w_v[j]),
          .o_z_c (w_z[j])
        );
      end
    end

    if (lzc_is_cut(k, L, STAGES)) begin : g_cut
      logic [NK-1:0]        r_v;
      logic [NK-1:0][k-1:0] r_z;
      always_ff @(posedge clock) begin
        if (w_en) begin
          r_v <= w_v;
          r_z <= w_z;
        end
      end
      assign w_pv = r_v;
      assign w_pz = r_z;
    end else begin : g_pass
      assign w_pv = w_v;
      assign w_pz = w_z;
    end
  end

  // An all-zero operand reports WIDTH rather than the tree's saturated count.
  always_comb begin
    w_root   = '0;
    w_root.v = g_lvl[L].w_pv[0];
    w_root.z = LZC_ZW_MAX'(g_lvl[L].w_pz[0]);
    w_count  = w_root.v ? CW'(WIDTH) : CW'(w_root.z);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_vld   <= '0;
      r_count <= '0;
      r_zero  <= 1'b0;
    end else if (w_en) begin
      r_vld   <= STAGES'({r_vld, ivalid});
      r_count <= w_count;
      r_zero  <= w_root.v;
    end
  end

`ifdef LZC_SKID_EN
  logic [1:0]    r_sk_cnt;
  logic [1:0]    w_sk_cnt_nxt;
  logic          r_oready;
  logic [CW-1:0] r_sk_count [2];
  logic [1:0]    r_sk_zero;
  logic          w_fin_vld;
  logic          w_push;
  logic          w_pop;
  logic          w_wr_idx;

  // Final stage bypasses the buffer only when it is empty and downstream is ready.
  assign w_fin_vld    = r_vld[STAGES-1];
  assign w_en         = r_oready;
  assign w_pop        = (r_sk_cnt != 2'd0) & iready;
  assign w_push       = w_en & w_fin_vld & ~((r_sk_cnt == 2'd0) & iready);
  assign w_wr_idx     = (r_sk_cnt == 2'd1) & ~w_pop;
  assign w_sk_cnt_nxt = r_sk_cnt + 2'(w_push) - 2'(w_pop);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_sk_cnt <= 2'd0;
      r_oready <= 1'b1;
    end else begin
      r_sk_cnt <= w_sk_cnt_nxt;
      r_oready <= (w_sk_cnt_nxt != 2'd2);
    end
  end

  always_ff @(posedge clock) begin
    if (w_pop) begin
      r_sk_count[0] <= r_sk_count[1];
      r_sk_zero[0]  <= r_sk_zero[1];
    end
    if (w_push) begin
      r_sk_count[w_wr_idx] <= r_count;
      r_sk_zero[w_wr_idx]  <= r_zero;
    end
  end

  assign oready = r_oready;
  assign ovalid = (r_sk_cnt != 2'd0) | w_fin_vld;
  assign count  = (r_sk_cnt != 2'd0) ? r_sk_count[0] : r_count;
  assign zero   = (r_sk_cnt != 2'd0) ? r_sk_zero[0]  : r_zero;
`else
  assign w_en   = ~r_vld[STAGES-1] | iready;
  assign oready = w_en;
  assign ovalid = r_vld[STAGES-1];
  assign count  = r_count;
  assign zero   = r_zero;
`endif

endmodule

// File: tb/tb_lzc_pipe_module.sv
// Scoreboard bench for lzc_pipe_module: directed latency/stall/reset scenarios
// on a 32-bit, 2-stage instance plus random streams on three other configurations.
`timescale 1ns/1ps
module tb_lzc_pipe_module;

  localparam int unsigned W  = 32;
  localparam int unsigned S  = 2;
  localparam int          NR = 2500;

  typedef struct {
    logic [6:0] cnt;
    logic       zero;
    int         t_in;
    bit         chk_lat;
  } exp_t;

  logic        clock = 1'b0;
  logic        resetn;
  logic        ivalid, oready, mode, ovalid, iready, zero;
  logic [31:0] datain_a;
  logic [5:0]  count;

  logic        xv_i [3];
  logic        xr_o [3];
  logic        xv_o [3];
  logic        xz   [3];
  logic        xr_i, xm;
  logic [63:0] xd;
  logic [3:0]  c8;
  logic [5:0]  c32;
  logic [6:0]  c64;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   lat_chk = 1'b0;
  bit   in_fire = 1'b0;

  always #5 clock = ~clock;

  lzc_pipe_module #(.WIDTH(W), .STAGES(S)) u_dut (
    .clock(clock), .resetn(resetn), .ivalid(ivalid), .oready(oready),
    .datain_a(datain_a), .mode(mode), .ovalid(ovalid), .iready(iready),
    .count(count), .zero(zero)
  );

  lzc_pipe_module #(.WIDTH(8), .STAGES(3)) u_w8 (
    .clock(clock), .resetn(resetn), .ivalid(xv_i[0]), .oready(xr_o[0]),
    .datain_a(xd[7:0]), .mode(xm), .ovalid(xv_o[0]), .iready(xr_i),
    .count(c8), .zero(xz[0])
  );

  lzc_pipe_module #(.WIDTH(32), .STAGES(5)) u_w32 (
    .clock(clock), .resetn(resetn), .ivalid(xv_i[1]), .oready(xr_o[1]),
    .datain_a(xd[31:0]), .mode(xm), .ovalid(xv_o[1]), .iready(xr_i),
    .count(c32), .zero(xz[1])
  );

  lzc_pipe_module #(.WIDTH(64), .STAGES(1)) u_w64 (
    .clock(clock), .resetn(resetn), .ivalid(xv_i[2]), .oready(xr_o[2]),
    .datain_a(xd), .mode(xm), .ovalid(xv_o[2]), .iready(xr_i),
    .count(c64), .zero(xz[2])
  );

  // Reference: scan from the MSB (leading) or LSB (trailing) for the first one.
  function automatic logic [6:0] ref_cnt(input logic [63:0] d, input int w, input logic m);
    for (int i = 0; i < w; i++) begin
      if (d[m ? i : (w - 1 - i)]) return 7'(i);
    end
    return 7'(w);
  endfunction

  function automatic logic [63:0] rnd_op(input int w);
    logic [63:0] d;
    d = {$urandom, $urandom} >> (64 - w);
    d = d >> $urandom_range(w);
    if ($urandom_range(15) == 0) d = '0;
    return d;
  endfunction

  function automatic int wsel(input int k);
    case (k)
      0:       return 8;
      1:       return 32;
      default: return 64;
    endcase
  endfunction

  function automatic logic [6:0] xcount(input int k);
    case (k)
      0:       return 7'(c8);
      1:       return 7'(c32);
      default: return 7'(c64);
    endcase
  endfunction

  // One cycle on the main instance: retire outputs against the scoreboard, log accepts.
  task automatic tick();
    exp_t e;
    #1;
    in_fire = ivalid & oready;
    if (ovalid & iready) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: count=%0d zero=%0d, required no output", count, zero);
      end else begin
        e = q.pop_front();
        if ({1'b0, count} !== e.cnt || zero !== e.zero) begin
          n_fail++;
          $display("FAIL result: count=%0d zero=%0d, required count=%0d zero=%0d",
                   count, zero, e.cnt, e.zero);
        end
        if (e.chk_lat) begin
          n_tests++;
          if ((cyc - e.t_in) != S) begin
            n_fail++;
            $display("FAIL latency: %0d cycles, required %0d", cyc - e.t_in, S);
          end
        end
      end
    end
    if (in_fire) begin
      e.cnt     = ref_cnt({32'h0, datain_a}, W, mode);
      e.zero    = (datain_a == 32'h0);
      e.t_in    = cyc;
      e.chk_lat = lat_chk;
      q.push_back(e);
    end
    @(negedge clock);
    cyc++;
  endtask

  task automatic drain();
    ivalid = 1'b0;
    iready = 1'b1;
    for (int c = 0; c < 64 && q.size() != 0; c++) tick();
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d results pending, required 0", q.size());
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; ivalid = 1'b0; iready = 1'b1; datain_a = '0; mode = 1'b0;
    xr_i = 1'b1; xm = 1'b0; xd = '0;
    for (int k = 0; k < 3; k++) xv_i[k] = 1'b0;
    repeat (3) @(negedge clock);
    n_tests++;
    if (ovalid !== 1'b0 || count !== 6'd0 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: ovalid=%b count=%0d zero=%b, required 0 0 0", ovalid, count, zero);
    end
    resetn = 1'b1;
    #1;
    n_tests++;
    if (oready !== 1'b1 || ovalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: oready=%b ovalid=%b, required 1 0", oready, ovalid);
    end
    @(negedge clock);
  endtask

  task automatic test_mode(input logic m, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c);
    logic [31:0] ops [3];
    ops[0] = a; ops[1] = b; ops[2] = c;
    lat_chk = 1'b1; iready = 1'b1; mode = m;
    for (int i = 0; i < 3; i++) begin
      ivalid = 1'b1; datain_a = ops[i];
      tick();
    end
    drain();
    lat_chk = 1'b0;
  endtask

  task automatic test_stall();
    logic [5:0] held_c;
    logic       held_z, r0, r1;
    iready = 1'b1; ivalid = 1'b1; mode = 1'b0; datain_a = 32'(rnd_op(32));
    for (int i = 0; i < S + 2; i++) begin
      tick();
      if (in_fire) datain_a = 32'(rnd_op(32));
    end
    iready = 1'b0;
    held_c = count; held_z = zero;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (ovalid !== 1'b1 || count !== held_c || zero !== held_z) begin
        n_fail++;
        $display("FAIL stall_hold: ovalid=%b count=%0d zero=%b, required 1 %0d %b",
                 ovalid, count, zero, held_c, held_z);
      end
      tick();
      if (in_fire) datain_a = 32'(rnd_op(32));
    end
    n_tests++;
    if (oready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_oready: oready=%b, required 0", oready);
    end
    r0 = oready;
    iready = 1'b1;
    #1;
    r1 = oready;
    n_tests++;
`ifdef LZC_SKID_EN
    if (r1 !== r0) begin
      n_fail++;
      $display("FAIL ready_path: oready moved %b->%b with iready, required no change", r0, r1);
    end
`else
    if (r0 !== 1'b0 || r1 !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_path: oready %b->%b, required 0->1", r0, r1);
    end
`endif
    drain();
  endtask

`ifdef LZC_SKID_EN
  task automatic test_skid_fill();
    int acc = 0;
    iready = 1'b0; ivalid = 1'b1; mode = 1'b1; datain_a = 32'(rnd_op(32));
    for (int i = 0; i < S + 4; i++) begin
      tick();
      if (in_fire) begin
        acc++;
        datain_a = 32'(rnd_op(32));
      end
    end
    n_tests++;
    if (acc != S + 2 || oready !== 1'b0) begin
      n_fail++;
      $display("FAIL skid_fill: accepted=%0d oready=%b, required %0d 0", acc, oready, S + 2);
    end
    drain();
  endtask
`endif

  task automatic test_mid_reset();
    iready = 1'b0; ivalid = 1'b1; mode = 1'b0;
    datain_a = 32'h0000_0100; tick();
    datain_a = 32'h0040_0000; tick();
    ivalid = 1'b0;
    n_tests++;
    if (ovalid !== 1'b1) begin
      n_fail++;
      $display("FAIL inflight_setup: ovalid=%b, required 1", ovalid);
    end
    #3;
    resetn = 1'b0;
    #1;
    n_tests++;
    if (ovalid !== 1'b0 || count !== 6'd0 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: ovalid=%b count=%0d zero=%b, required 0 0 0", ovalid, count, zero);
    end
    q.delete();
    @(negedge clock);
    resetn = 1'b1;
    #1;
    n_tests++;
    if (oready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_oready: oready=%b, required 1", oready);
    end
    @(negedge clock);
    iready = 1'b1;
    repeat (6) tick();
    n_tests++;
    if (ovalid !== 1'b0) begin
      n_fail++;
      $display("FAIL discarded_result: ovalid=%b, required 0", ovalid);
    end
    lat_chk = 1'b1;
    ivalid = 1'b1; datain_a = 32'h0000_0400; mode = 1'b1;
    tick();
    drain();
    lat_chk = 1'b0;
  endtask

  task automatic test_random();
    int sent = 0;
    ivalid = 1'b0;
    for (int c = 0; c < 30000 && (sent < NR || q.size() != 0); c++) begin
      if (!ivalid && sent < NR && $urandom_range(1) == 1) begin
        ivalid = 1'b1; datain_a = 32'(rnd_op(32)); mode = 1'($urandom_range(1));
      end
      iready = 1'($urandom_range(1));
      tick();
      if (in_fire) begin
        sent++;
        ivalid = 1'b0;
      end
    end
    n_tests++;
    if (sent != NR || q.size() != 0) begin
      n_fail++;
      $display("FAIL random_main: sent=%0d pending=%0d, required %0d 0", sent, q.size(), NR);
    end
  endtask

  task automatic test_random_widths();
    exp_t e;
    int   sent, w, t;
    bit   fin, fout;
    for (int k = 0; k < 3; k++) begin
      w = wsel(k); sent = 0; t = 0;
      xv_i[k] = 1'b0;
      for (int c = 0; c < 30000 && (sent < NR || q.size() != 0); c++) begin
        if (!xv_i[k] && sent < NR && $urandom_range(1) == 1) begin
          xv_i[k] = 1'b1; xd = rnd_op(w); xm = 1'($urandom_range(1));
        end
        xr_i = 1'($urandom_range(1));
        #1;
        fin  = xv_i[k] & xr_o[k];
        fout = xv_o[k] & xr_i;
        if (fout) begin
          n_tests++;
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL rand_w%0d_extra: count=%0d, required no output", w, xcount(k));
          end else begin
            e = q.pop_front();
            if (xcount(k) !== e.cnt || xz[k] !== e.zero) begin
              n_fail++;
              $display("FAIL rand_w%0d: count=%0d zero=%b, required count=%0d zero=%b",
                       w, xcount(k), xz[k], e.cnt, e.zero);
            end
          end
        end
        if (fin) begin
          e.cnt = ref_cnt(xd, w, xm); e.zero = (xd == 64'h0); e.t_in = t; e.chk_lat = 1'b0;
          q.push_back(e);
          sent++;
        end
        @(negedge clock);
        t++;
        if (fin) xv_i[k] = 1'b0;
      end
      xv_i[k] = 1'b0;
      n_tests++;
      if (sent != NR || q.size() != 0) begin
        n_fail++;
        $display("FAIL rand_w%0d_done: sent=%0d pending=%0d, required %0d 0", w, sent, q.size(), NR);
      end
      q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_mode(1'b0, 32'h0001_0000, 32'h8000_0000, 32'h0000_0000);
    test_mode(1'b1, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);
    test_stall();
`ifdef LZC_SKID_EN
    test_skid_fill();
`endif
    test_mid_reset();
    test_random();
    test_random_widths();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
